mem_arbiter: RTL and testbench

- Shares the single main-memory port between the instruction-cache refill path and the data-cache refill/write-back path.
- The D-side carries the memread/memwrite traffic that the control unit generates, after D-cache misses.
- Each transaction is one line. The block serialises requests with round-robin arbitration, registers the memory request, returns read data with a one-cycle ack, and aborts hung transactions with a timeout error.

---
 rtl/mem_arbiter.sv | 103 ++++++++++
 tb/tb_mem_arbiter.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one main-memory line port between the I-cache fill path
// and the D-cache fill/write-back path, with registered request and a hung-transaction timeout.
module mem_arbiter #(
  parameter int WIDTH   = 128,
  parameter int TIMEOUT = 256
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ic_req,
  input  logic [31:0]      ic_addr,
  output logic [WIDTH-1:0] ic_data,
  output logic             ic_ack,
  input  logic             dc_req,
  input  logic             dc_we,
  input  logic [31:0]      dc_addr,
  input  logic [WIDTH-1:0] dc_wdata,
  output logic [WIDTH-1:0] dc_rdata,
  output logic             dc_ack,
  output logic             mem_req,
  output logic             mem_we,
  output logic [31:0]      mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_rdata,
  input  logic             mem_ack,
  output logic             bus_err,
  output logic             last_grant
);

  localparam int OFS = $clog2(WIDTH / 8);
  localparam int CW  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] TMO_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D, RESP} state_t;

  state_t        state;
  logic [CW-1:0] tmo_cnt;
  logic          pick_d;
  logic          timed_out;

  // On a tie the side that was not served last wins; a lone requester always wins.
  assign pick_d    = dc_req && (!ic_req || !last_grant);
  assign timed_out = (TIMEOUT > 0) && (tmo_cnt == TMO_LAST);

  always_ff @(posedge clk) begin
    if (!reset) begin
      // NOTE: the line registers are cleared too, since every output must read 0 out of reset.
      state      <= IDLE;
      tmo_cnt    <= '0;
      ic_data    <= '0;
      ic_ack     <= 1'b0;
      dc_rdata   <= '0;
      dc_ack     <= 1'b0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      bus_err    <= 1'b0;
      last_grant <= 1'b0;
    end else begin
      // NOTE: pulse outputs default low here so each is high for exactly the one RESP cycle.
      ic_ack  <= 1'b0;
      dc_ack  <= 1'b0;
      bus_err <= 1'b0;
      unique case (state)
        IDLE: begin
          tmo_cnt <= '0;
          if (ic_req || dc_req) begin
            state      <= pick_d ? GRANT_D : GRANT_I;
            last_grant <= pick_d;
            mem_req    <= 1'b1;
            mem_we     <= pick_d && dc_we;
            mem_addr   <= pick_d ? {dc_addr[31:OFS], {OFS{1'b0}}}
                                 : {ic_addr[31:OFS], {OFS{1'b0}}};
            mem_wdata  <= pick_d ? dc_wdata : '0;
          end
        end
        GRANT_I, GRANT_D: begin
          if (mem_ack || timed_out) begin
            state   <= RESP;
            mem_req <= 1'b0;
            ic_ack  <= (state == GRANT_I);
            dc_ack  <= (state == GRANT_D);
            bus_err <= !mem_ack;
            // A timed-out transaction returns an all-zero line; a completed write-back keeps dc_rdata.
            if (state == GRANT_I)
              ic_data <= mem_ack ? mem_rdata : '0;
            else if (!mem_we || !mem_ack)
              dc_rdata <= mem_ack ? mem_rdata : '0;
          end else begin
            tmo_cnt <= tmo_cnt + CW'(1);
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: randomized and directed requests, a reference model
// that predicts grant order and results, a memory responder, and a scoreboard monitor.
`timescale 1ns/1ps
module tb_mem_arbiter;
  localparam int W   = 128;
  localparam int TMO = 8;
  localparam int LB  = W / 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          ic_req, ic_ack, dc_req, dc_we, dc_ack;
  logic [31:0]   ic_addr, dc_addr, mem_addr;
  logic [W-1:0]  ic_data, dc_wdata, dc_rdata, mem_wdata, mem_rdata;
  logic          mem_req, mem_we, mem_ack, bus_err, last_grant;

  mem_arbiter #(.WIDTH(W), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset),
    .ic_req(ic_req), .ic_addr(ic_addr), .ic_data(ic_data), .ic_ack(ic_ack),
    .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
    .dc_rdata(dc_rdata), .dc_ack(dc_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .bus_err(bus_err), .last_grant(last_grant)
  );

  typedef struct {
    bit           en;
    logic [31:0]  addr;
    bit           we;
    logic [W-1:0] wdata;
    int           lat;     // cycles after mem_req before the memory acks; >= TMO means never
    logic [W-1:0] rdata;
  } side_t;

  typedef struct { int lat; logic [W-1:0] rdata; } mem_op_t;

  typedef struct {
    bit           d;
    logic [31:0]  addr;
    bit           we;
    logic [W-1:0] wdata;
    logic [W-1:0] ic;
    logic [W-1:0] dc;
    bit           err;
    int           req_cycles;
  } exp_t;

  mem_op_t mem_q[$];
  exp_t    exp_q[$];
  int      ack_times[$];

  int n_checks = 0;
  int n_pass   = 0;
  int cycle    = 0;
  always @(posedge clk) cycle <= cycle + 1;

  // Reference state: what each data register and last_grant should hold.
  bit           m_last = 1'b0;
  logic [W-1:0] m_ic   = '0;
  logic [W-1:0] m_dc   = '0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
  endtask

  function automatic logic [W-1:0] rand_line();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic side_t mk(input bit en, input logic [31:0] addr, input bit we,
                               input logic [W-1:0] wdata, input int lat, input logic [W-1:0] rdata);
    side_t s;
    s.en = en; s.addr = addr; s.we = we; s.wdata = wdata; s.lat = lat; s.rdata = rdata;
    return s;
  endfunction

  // ---------------- memory responder ----------------
  bit           busy = 1'b0;
  bit           unstable = 1'b0;
  int           mcyc = 0;
  mem_op_t      cur;
  logic [31:0]  obs_addr;
  logic         obs_we;
  logic [W-1:0] obs_wdata;

  initial begin
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      mem_rdata = rand_line();
      mem_ack   = 1'b0;
      if (!mem_req) begin
        busy    = 1'b0;
        mem_ack = ($urandom_range(0, 3) == 0);   // stray acks outside a grant must be ignored
      end else begin
        if (!busy) begin
          busy      = 1'b1;
          mcyc      = 0;
          unstable  = 1'b0;
          obs_addr  = mem_addr;
          obs_we    = mem_we;
          obs_wdata = mem_wdata;
          check("mem_req_expected", mem_q.size() != 0, 1);
          if (mem_q.size() != 0) cur = mem_q.pop_front();
          else begin cur.lat = 1000; cur.rdata = '0; end
        end else if (mem_addr !== obs_addr || mem_we !== obs_we || mem_wdata !== obs_wdata) begin
          unstable = 1'b1;
        end
        if (mcyc == cur.lat) begin
          mem_ack   = 1'b1;
          mem_rdata = cur.rdata;
        end
        mcyc++;
      end
    end
  end

  // ---------------- scoreboard monitor ----------------
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (bus_err && !ic_ack && !dc_ack) check("bus_err_without_ack", bus_err, 0);
      if (ic_ack || dc_ack) begin
        check("ack_exclusive", ic_ack & dc_ack, 0);
        check("ack_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("ack_side", dc_ack, e.d);
          check("last_grant", last_grant, e.d);
          check("bus_err", bus_err, e.err);
          check("ic_data", ic_data, e.ic);
          check("dc_rdata", dc_rdata, e.dc);
          check("mem_addr", obs_addr, e.addr);
          check("mem_we", obs_we, e.we);
          if (e.we) check("mem_wdata", obs_wdata, e.wdata);
          check("mem_req_cycles", mcyc, e.req_cycles);
          check("mem_stable", unstable, 0);
        end
      end
    end
  end

  // ---------------- reference model + driver ----------------
  task automatic model_txn(input bit is_d, input side_t s);
    exp_t    e;
    mem_op_t m;
    m.lat = s.lat; m.rdata = s.rdata;
    mem_q.push_back(m);
    e.d          = is_d;
    e.addr       = (s.addr / LB) * LB;
    e.we         = is_d && s.we;
    e.wdata      = s.wdata;
    e.err        = (s.lat >= TMO);
    e.req_cycles = e.err ? TMO : s.lat + 1;
    if (e.err) begin
      if (is_d) m_dc = '0; else m_ic = '0;
    end else if (!e.we) begin
      if (is_d) m_dc = s.rdata; else m_ic = s.rdata;
    end
    e.ic   = m_ic;
    e.dc   = m_dc;
    m_last = is_d;
    exp_q.push_back(e);
  endtask

  task automatic run_round(input side_t si, input side_t sd);
    bit first_d;
    int pending;
    int guard;
    first_d = (si.en && sd.en) ? !m_last : sd.en;
    if (first_d) begin
      model_txn(1'b1, sd);
      if (si.en) model_txn(1'b0, si);
    end else begin
      model_txn(1'b0, si);
      if (sd.en) model_txn(1'b1, sd);
    end
    @(negedge clk);
    ic_req = si.en; ic_addr = si.addr;
    dc_req = sd.en; dc_we = sd.we; dc_addr = sd.addr; dc_wdata = sd.wdata;
    pending = int'(si.en) + int'(sd.en);
    guard   = 0;
    while (pending > 0 && guard < 200) begin
      @(negedge clk);
      guard++;
      if (ic_ack) begin ic_req = 1'b0; pending--; ack_times.push_back(cycle); end
      if (dc_ack) begin dc_req = 1'b0; pending--; ack_times.push_back(cycle); end
      // A side that has been served is idle; scramble its inputs to prove they are ignored.
      if (!ic_req) ic_addr = $urandom();
      if (!dc_req) begin dc_addr = $urandom(); dc_we = $urandom(); dc_wdata = rand_line(); end
    end
    check("round_completed", pending, 0);
    ic_req = 1'b0;
    dc_req = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ic_data"}, ic_data, 0);
    check({tag, "_ic_ack"}, ic_ack, 0);
    check({tag, "_dc_rdata"}, dc_rdata, 0);
    check({tag, "_dc_ack"}, dc_ack, 0);
    check({tag, "_mem_req"}, mem_req, 0);
    check({tag, "_mem_we"}, mem_we, 0);
    check({tag, "_mem_addr"}, mem_addr, 0);
    check({tag, "_mem_wdata"}, mem_wdata, 0);
    check({tag, "_bus_err"}, bus_err, 0);
    check({tag, "_last_grant"}, last_grant, 0);
  endtask

  initial begin
    side_t none;
    int    guard;
    none = mk(1'b0, '0, 1'b0, '0, 0, '0);
    reset = 1'b0;
    ic_req = 1'b0; ic_addr = '0;
    dc_req = 1'b0; dc_we = 1'b0; dc_addr = '0; dc_wdata = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b1;

    // Contention straight out of reset: D, I, D, I, each 3 cycles with a same-cycle-ack memory.
    ack_times.delete();
    for (int r = 0; r < 2; r++)
      run_round(mk(1'b1, $urandom(), 1'b0, '0, 0, rand_line()),
                mk(1'b1, $urandom(), 1'b0, rand_line(), 0, rand_line()));
    check("contention_ack_count", ack_times.size(), 4);
    for (int k = 1; k < ack_times.size(); k++)
      check("txn_spacing", ack_times[k] - ack_times[k-1], 3);

    // Single I fill, memory acks two cycles after mem_req.
    run_round(mk(1'b1, 32'h0040_0014, 1'b0, '0, 2, {4{32'hA5A5_A5A5}}), none);

    // D write-back leaves dc_rdata alone.
    run_round(none, mk(1'b1, 32'h1000_0008, 1'b1, {4{32'h1234_5678}}, 1, rand_line()));

    // Memory never acks: timeout error, then a normal transaction.
    run_round(none, mk(1'b1, 32'h2000_0040, 1'b0, '0, TMO + 5, rand_line()));
    run_round(none, mk(1'b1, 32'h2000_0050, 1'b0, '0, 1, rand_line()));

    // Ack arrives on the final timeout cycle: data wins, no error.
    run_round(none, mk(1'b1, 32'h2000_0060, 1'b0, '0, TMO - 1, rand_line()));
    run_round(mk(1'b1, 32'h3000_0004, 1'b0, '0, TMO - 1, rand_line()), none);

    // Reset in the middle of a D grant: no ack, everything zero, next tie goes to D.
    mem_q.push_back('{lat: 1000, rdata: '0});
    @(negedge clk);
    dc_req = 1'b1; dc_we = 1'b0; dc_addr = 32'h4000_0000;
    guard = 0;
    while (!mem_req && guard < 20) begin @(negedge clk); guard++; end
    check("abort_grant_seen", mem_req, 1);
    repeat (2) @(negedge clk);
    reset  = 1'b0;
    dc_req = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    check_reset_outputs("mid_reset");
    m_last = 1'b0; m_ic = '0; m_dc = '0;
    run_round(mk(1'b1, $urandom(), 1'b0, '0, 1, rand_line()),
              mk(1'b1, $urandom(), 1'b0, '0, 0, rand_line()));

    // Randomized traffic.
    for (int r = 0; r < 60; r++) begin
      side_t si, sd;
      int    sel;
      bit    wi, wd;
      int    lat_i, lat_d;
      wi = $urandom();
      wd = $urandom();
      if (!wi && !wd) wd = 1'b1;
      sel = $urandom_range(0, 9);
      lat_i = (sel < 7) ? $urandom_range(0, 3) : (sel == 7) ? TMO - 1 : (sel == 8) ? TMO + 3 : TMO - 2;
      sel = $urandom_range(0, 9);
      lat_d = (sel < 7) ? $urandom_range(0, 3) : (sel == 7) ? TMO - 1 : (sel == 8) ? TMO + 3 : TMO - 2;
      si = mk(wi, $urandom(), 1'b0, '0, lat_i, rand_line());
      sd = mk(wd, $urandom(), bit'($urandom()), rand_line(), lat_d, rand_line());
      run_round(si, sd);
    end

    repeat (5) @(negedge clk);
    check("exp_q_drained", exp_q.size(), 0);
    check("mem_q_drained", mem_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
